bias_pe_sequencer: RTL and testbench

//  Drives the bias PE one neuron at a time: reads each stored bias, issues it as init_bias with a one-cycle PE enable,

---
 rtl/bias_pkg.sv | 25 ++
 rtl/bias_regfile.sv | 36 +++
 rtl/bias_pe_sequencer.sv | 159 +++++++++++++++
 tb/tb_bias_pe_sequencer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/bias_pkg.sv
// Shared types for the bias PE sequencer: word format, PE result payload, FSM states.
package bias_pkg;

   localparam int unsigned DATA_W = 16;
   localparam int unsigned FRAC_W = 8;

   // Q8.8 fixed-point word
   typedef logic [DATA_W-1:0] fixed_16;

   // PE result payload as presented on the PE result port
   typedef struct packed {
      fixed_16 net_sum;
      fixed_16 bias_change;
   } bias_struct;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_ISSUE   = 3'd1,
      S_WAIT    = 3'd2,
      S_CAPTURE = 3'd3,
      S_EMIT    = 3'd4,
      S_DONE    = 3'd5
   } seq_state_t;

endpackage

// File: rtl/bias_regfile.sv
// Per-layer bias store: one synchronous write port, one asynchronous read port.
module bias_regfile #(
   parameter int unsigned N_NEURON = 8,
   parameter int unsigned DATA_W   = 16,
   localparam int unsigned IDX_W   = $clog2(N_NEURON)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [IDX_W-1:0]  waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [IDX_W-1:0]  raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [N_NEURON];
   logic              in_range;

   // Addresses beyond the populated entries are dropped rather than aliased
   assign in_range = ({1'b0, waddr} < (IDX_W+1)'(N_NEURON));

   // Storage update: reset clears every entry, otherwise single-entry write
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < int'(N_NEURON); i++) begin
            mem[i] <= '0;
         end
      end else if (we && in_range) begin
         mem[waddr] <= wdata;
      end
   end

   // Combinational read of the current neuron's bias
   assign rdata = mem[raddr];

endmodule

// File: rtl/bias_pe_sequencer.sv
// Steps the bias PE through every neuron, streams net_sum out, optionally writes bias_change back.
module bias_pe_sequencer #(
   parameter int unsigned N_NEURON = 8,
   parameter int unsigned DATA_W   = 16,
   parameter int unsigned PE_LAT   = 1,
   localparam int unsigned IDX_W   = $clog2(N_NEURON)
) (
   input  logic              ap_clk,
   input  logic              ap_rst,
   input  logic              ap_ce,
   input  logic              start,
   input  logic              training,
   output logic              busy,
   output logic              done,
   input  logic              load_valid,
   input  logic [IDX_W-1:0]  load_idx,
   input  logic [DATA_W-1:0] load_data,
   output logic [IDX_W-1:0]  pe_idx,
   output logic              pe_ce,
   output logic [DATA_W-1:0] pe_init_bias,
   input  logic [DATA_W-1:0] pe_net_sum,
   input  logic [DATA_W-1:0] pe_bias_change,
   output logic              net_valid,
   input  logic              net_ready,
   output logic [IDX_W-1:0]  net_idx,
   output logic [DATA_W-1:0] net_data
);

   import bias_pkg::*;

   localparam int unsigned CNT_W = (PE_LAT > 1) ? $clog2(PE_LAT) : 1;

   seq_state_t        state_q, state_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              trn_q, trn_d;
   logic              net_valid_q, net_valid_d;
   logic [IDX_W-1:0]  net_idx_q, net_idx_d;
   logic [DATA_W-1:0] net_data_q, net_data_d;
   logic              busy_q, done_q;

   logic              wb_we;
   logic [IDX_W-1:0]  wb_addr;
   logic [DATA_W-1:0] wb_data;

   // Single write port shared by IDLE loads and CAPTURE write-back (never both in one state)
   bias_regfile #(
      .N_NEURON (N_NEURON),
      .DATA_W   (DATA_W)
   ) u_regfile (
      .clk   (ap_clk),
      .rst   (ap_rst),
      .we    (wb_we && ap_ce),
      .waddr (wb_addr),
      .wdata (wb_data),
      .raddr (idx_q),
      .rdata (pe_init_bias)
   );

   // Next-state, counters, skid register and write-port control
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      cnt_d       = cnt_q;
      trn_d       = trn_q;
      net_valid_d = net_valid_q;
      net_idx_d   = net_idx_q;
      net_data_d  = net_data_q;
      wb_we       = 1'b0;
      wb_addr     = load_idx;
      wb_data     = load_data;

      unique case (state_q)
         S_IDLE: begin
            wb_we = load_valid;
            if (start) begin
               trn_d   = training;
               idx_d   = '0;
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (PE_LAT > 1) begin
               cnt_d   = CNT_W'(PE_LAT - 1);
               state_d = S_WAIT;
            end else begin
               state_d = S_CAPTURE;
            end
         end
         S_WAIT: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               state_d = S_CAPTURE;
            end
         end
         S_CAPTURE: begin
            net_data_d  = pe_net_sum;
            net_idx_d   = idx_q;
            net_valid_d = 1'b1;
            wb_we       = trn_q;
            wb_addr     = idx_q;
            wb_data     = pe_bias_change;
            state_d     = S_EMIT;
         end
         S_EMIT: begin
            if (net_valid_q && net_ready) begin
               net_valid_d = 1'b0;
               if (idx_q == IDX_W'(N_NEURON - 1)) begin
                  state_d = S_DONE;
               end else begin
                  idx_d   = idx_q + IDX_W'(1);
                  state_d = S_ISSUE;
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and output registers; ap_ce low freezes everything
   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         state_q     <= S_IDLE;
         idx_q       <= '0;
         cnt_q       <= '0;
         trn_q       <= 1'b0;
         net_valid_q <= 1'b0;
         net_idx_q   <= '0;
         net_data_q  <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else if (ap_ce) begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         cnt_q       <= cnt_d;
         trn_q       <= trn_d;
         net_valid_q <= net_valid_d;
         net_idx_q   <= net_idx_d;
         net_data_q  <= net_data_d;
         busy_q      <= (state_d != S_IDLE);
         done_q      <= (state_d == S_DONE);
      end
   end

   // PE enable is suppressed whenever the clock enable is low
   assign pe_ce     = ap_ce && (state_q == S_ISSUE);
   assign pe_idx    = idx_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign net_valid = net_valid_q;
   assign net_idx   = net_idx_q;
   assign net_data  = net_data_q;

endmodule

// File: tb/tb_bias_pe_sequencer.sv
// Directed bench: DUT A (N=8, PE_LAT=1) and DUT B (N=6, PE_LAT=3) with registered stub PEs.
module tb_bias_pe_sequencer;

   localparam int unsigned NA = 8;
   localparam int unsigned LA = 1;
   localparam int unsigned NB = 6;
   localparam int unsigned LB = 3;

   logic        clk;
   logic        rst_a, rst_b, ce_a, ce_b, start_a, start_b, lv_a, lv_b;
   logic        training, net_ready;
   logic [2:0]  load_idx;
   logic [15:0] load_data;

   logic        a_busy, a_done, a_pe_ce, a_net_valid;
   logic [2:0]  a_pe_idx, a_net_idx;
   logic [15:0] a_init, a_net_data, a_sum, a_chg;
   logic        b_busy, b_done, b_pe_ce, b_net_valid;
   logic [2:0]  b_pe_idx, b_net_idx;
   logic [15:0] b_init, b_net_data, b_sum, b_chg;

   logic        sel;
   logic        o_busy, o_done, o_pe_ce, o_valid;
   logic [2:0]  o_pe_idx, o_nidx;
   logic [15:0] o_init, o_ndata;

   int n_pass, n_total;

   bias_pe_sequencer #(.N_NEURON(NA), .DATA_W(16), .PE_LAT(LA)) u_a (
      .ap_clk(clk), .ap_rst(rst_a), .ap_ce(ce_a), .start(start_a), .training(training),
      .busy(a_busy), .done(a_done), .load_valid(lv_a), .load_idx(load_idx), .load_data(load_data),
      .pe_idx(a_pe_idx), .pe_ce(a_pe_ce), .pe_init_bias(a_init), .pe_net_sum(a_sum),
      .pe_bias_change(a_chg), .net_valid(a_net_valid), .net_ready(net_ready),
      .net_idx(a_net_idx), .net_data(a_net_data));

   bias_pe_sequencer #(.N_NEURON(NB), .DATA_W(16), .PE_LAT(LB)) u_b (
      .ap_clk(clk), .ap_rst(rst_b), .ap_ce(ce_b), .start(start_b), .training(training),
      .busy(b_busy), .done(b_done), .load_valid(lv_b), .load_idx(load_idx), .load_data(load_data),
      .pe_idx(b_pe_idx), .pe_ce(b_pe_ce), .pe_init_bias(b_init), .pe_net_sum(b_sum),
      .pe_bias_change(b_chg), .net_valid(b_net_valid), .net_ready(net_ready),
      .net_idx(b_net_idx), .net_data(b_net_data));

   // Stub PEs: result registered on enable and held until the next enable
   always_ff @(posedge clk) begin
      if (a_pe_ce) begin
         a_sum <= a_init + 16'h0080;
         a_chg <= a_init - 16'h0010;
      end
      if (b_pe_ce) begin
         b_sum <= b_init + 16'h0080;
         b_chg <= b_init - 16'h0010;
      end
   end

   assign o_busy   = sel ? b_busy      : a_busy;
   assign o_done   = sel ? b_done      : a_done;
   assign o_pe_ce  = sel ? b_pe_ce     : a_pe_ce;
   assign o_valid  = sel ? b_net_valid : a_net_valid;
   assign o_pe_idx = sel ? b_pe_idx    : a_pe_idx;
   assign o_nidx   = sel ? b_net_idx   : a_net_idx;
   assign o_init   = sel ? b_init      : a_init;
   assign o_ndata  = sel ? b_net_data  : a_net_data;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic set_start(input logic v);
      if (sel) start_b = v; else start_a = v;
   endtask

   task automatic set_ce(input logic v);
      if (sel) ce_b = v; else ce_a = v;
   endtask

   task automatic set_load(input logic v, input int i, input logic [15:0] d);
      if (sel) lv_b = v; else lv_a = v;
      load_idx  = 3'(i);
      load_data = d;
   endtask

   task automatic load_all(input int n);
      for (int i = 0; i < n; i++) begin
         set_load(1'b1, i, 16'(32'h100 * i));
         tick();
      end
      set_load(1'b0, 0, 16'h0000);
   endtask

   // One full pass with optional back-pressure, clock-enable freeze and mid-pass pokes
   task automatic run_pass(input int n, input int lat, input logic trn, input int step,
                           input int off, input int stall_idx, input int stall_len,
                           input logic freeze, input logic poke, input string tag);
      int cyc, k, stalled, per, extra, exp_cyc;
      logic fin;
      per = lat + 2; k = 0; stalled = 0; fin = 1'b0; cyc = 0;
      extra = freeze ? 3 : 0;
      training = trn;
      set_start(1'b1);
      check({tag, "_busy_pre"}, 32'(o_busy), 32'd0);
      tick();
      set_start(1'b0);
      training = ~trn;
      cyc = 1;
      check({tag, "_busy_c1"}, 32'(o_busy), 32'd1);
      while (!fin && cyc < 300) begin
         if (freeze && cyc == 3) begin
            check({tag, "_frz_busy"}, 32'(o_busy), 32'd1);
            check({tag, "_frz_pe_ce"}, 32'(o_pe_ce), 32'd0);
         end
         if (o_valid) begin
            if (k == stall_idx && stalled < stall_len) begin
               net_ready = 1'b0;
               stalled++;
               check($sformatf("%s_stall_data%0d", tag, stalled), 32'(o_ndata), 32'(16'(step * k + off)));
               check($sformatf("%s_stall_pece%0d", tag, stalled), 32'(o_pe_ce), 32'd0);
            end else begin
               net_ready = 1'b1;
               exp_cyc = 2 + lat + per * k + extra + ((k >= stall_idx) ? stall_len : 0);
               check($sformatf("%s_idx%0d", tag, k), 32'(o_nidx), 32'(k));
               check($sformatf("%s_data%0d", tag, k), 32'(o_ndata), 32'(16'(step * k + off)));
               check($sformatf("%s_cyc%0d", tag, k), 32'(cyc), 32'(exp_cyc));
               k++;
            end
         end
         if (o_done) begin
            check({tag, "_done_cyc"}, 32'(cyc),
                  32'(n * per + 1 + extra + ((stall_idx < n) ? stall_len : 0)));
            check({tag, "_count"}, 32'(k), 32'(n));
            fin = 1'b1;
         end
         if (freeze && cyc == 2) set_ce(1'b0);
         if (freeze && cyc == 5) set_ce(1'b1);
         if (poke && cyc == 5) begin
            set_start(1'b1);
            set_load(1'b1, 2, 16'hDEAD);
         end
         if (poke && cyc == 6) begin
            set_start(1'b0);
            set_load(1'b0, 0, 16'h0000);
         end
         tick();
         cyc++;
      end
      check({tag, "_finished"}, 32'(fin), 32'd1);
      check({tag, "_busy_post"}, 32'(o_busy), 32'd0);
      check({tag, "_done_post"}, 32'(o_done), 32'd0);
   endtask

   initial begin
      int w;
      n_pass = 0; n_total = 0; sel = 1'b0;
      rst_a = 1'b1; rst_b = 1'b1; ce_a = 1'b1; ce_b = 1'b1;
      start_a = 1'b0; start_b = 1'b0; lv_a = 1'b0; lv_b = 1'b0;
      training = 1'b0; net_ready = 1'b1; load_idx = '0; load_data = '0;
      tick(); tick();

      // Reset state
      check("rst_busy", 32'(a_busy), 32'd0);
      check("rst_done", 32'(a_done), 32'd0);
      check("rst_valid", 32'(a_net_valid), 32'd0);
      check("rst_nidx", 32'(a_net_idx), 32'd0);
      check("rst_ndata", 32'(a_net_data), 32'd0);
      check("rst_pe_ce", 32'(a_pe_ce), 32'd0);
      check("rst_pe_idx", 32'(a_pe_idx), 32'd0);
      check("rst_init", 32'(a_init), 32'd0);
      check("rst_b_busy", 32'(b_busy), 32'd0);
      rst_a = 1'b0; rst_b = 1'b0;
      tick();

      // Inference, training, then inference on decremented biases (with mid-pass pokes)
      load_all(NA);
      run_pass(NA, LA, 1'b0, 32'h100, 32'h80, 99, 0, 1'b0, 1'b1, "inf1");
      run_pass(NA, LA, 1'b1, 32'h100, 32'h80, 99, 0, 1'b0, 1'b0, "trn");
      run_pass(NA, LA, 1'b0, 32'h100, 32'h70, 99, 0, 1'b0, 1'b0, "inf2");

      // Back-pressure on neuron 3
      load_all(NA);
      run_pass(NA, LA, 1'b0, 32'h100, 32'h80, 3, 5, 1'b0, 1'b0, "stall");

      // Reset in the middle of a pass
      training = 1'b0;
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
      w = 0;
      while (a_pe_idx != 3'd4 && w < 100) begin
         tick();
         w++;
      end
      check("mid_reach_idx4", 32'(a_pe_idx), 32'd4);
      rst_a = 1'b1;
      tick();
      rst_a = 1'b0;
      check("mid_busy", 32'(a_busy), 32'd0);
      check("mid_valid", 32'(a_net_valid), 32'd0);
      check("mid_done", 32'(a_done), 32'd0);
      check("mid_pe_idx", 32'(a_pe_idx), 32'd0);
      for (int i = 0; i < 4; i++) begin
         tick();
         check($sformatf("mid_nodone%0d", i), 32'(a_done), 32'd0);
      end
      run_pass(NA, LA, 1'b0, 32'h0, 32'h80, 99, 0, 1'b0, 1'b0, "cleared");
      load_all(NA);
      run_pass(NA, LA, 1'b0, 32'h100, 32'h80, 99, 0, 1'b0, 1'b0, "restart");

      // DUT B: out-of-range loads dropped, base timing, then clock-enable freeze mid-WAIT
      sel = 1'b1;
      load_all(NB);
      set_load(1'b1, 6, 16'hBEEF);
      tick();
      set_load(1'b1, 7, 16'hBEEF);
      tick();
      set_load(1'b0, 0, 16'h0000);
      check("b_init0", 32'(o_init), 32'd0);
      run_pass(NB, LB, 1'b0, 32'h100, 32'h80, 99, 0, 1'b0, 1'b0, "b_base");
      run_pass(NB, LB, 1'b0, 32'h100, 32'h80, 99, 0, 1'b1, 1'b0, "b_freeze");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
